conv_window_ctrl: RTL
=====================

# conv_window_ctrl

Raster-scan sequencer for the 3x3 convolution front end. Accepts one frame of pixels over a valid/ready stream, clears and writes the line-buffer chain, and tracks row/column position. Flags each pixel that completes a full 3x3 window. Sits between the pixel input stream and the two cascaded line buffers that feed the window registers.

## Interface
- IMG_W, 8: pixels per row; equals line-buffer DEPTH; legal range >= 3
- IMG_H, 8: rows per frame; legal range >= 3
- WIDTH, 8: pixel width in bits
- i_clk  in  1  clock; all logic on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  frame start request; sampled only in IDLE
- i_px_valid  in  1  input pixel valid
- i_px_data  in  WIDTH  input pixel
- o_px_ready  out  1  controller accepts a pixel this cycle
- o_lb_clear  out  1  one-cycle clear pulse to both line buffers (top level: lb resetn = ~(i_reset | o_lb_clear))
- o_lb_wr_valid  out  1  line-buffer write strobe (both buffers, cascaded)
- o_lb_wr_data  out  WIDTH  pixel written to line buffer 0 and window column
- o_win_valid  out  1  current write completes a 3x3 window
- o_win_col  out  CW  column of written pixel, CW = max(1, $clog2(IMG_W))
- o_win_row  out  RW  row of written pixel, RW = max(1, $clog2(IMG_H))
- o_busy  out  1  high in every state except IDLE
- o_frame_done  out  1  one-cycle pulse after last pixel written

## Operation
- FSM states: IDLE, CLEAR, STREAM, DONE.
- IDLE:
  - Outputs are quiet and o_px_ready = 0.
  - i_start = 1 moves to CLEAR.
- CLEAR:
  - Lasts exactly one cycle with o_lb_clear = 1.
  - Zeroes the column and row counters, then moves to STREAM.
- STREAM:
  - o_px_ready = 1.
  - A pixel is accepted when i_px_valid & o_px_ready.
  - On accept, the column counter increments. At IMG_W-1 it wraps to 0 and the row counter increments.
  - Accepting pixel (IMG_H-1, IMG_W-1) moves to DONE. That is the final accept; no pixel beyond W*H is taken.
  - A cycle with i_px_valid = 0 is a bubble: no write, counters hold.
- DONE:
  - Lasts one cycle with o_frame_done = 1 and o_px_ready = 0, then moves to IDLE.
- Window flag: o_win_valid = 1 for an accepted pixel when row >= 2 and col >= 2, using that pixel's own position.
- Per frame: exactly W*H write strobes and (W-2)*(H-2) window strobes.
- Ignored inputs:
  - i_start outside IDLE.
  - i_px_valid outside STREAM.
  - i_px_data when not accepted.
- Reset mid-frame: immediate return to IDLE; counters and all outputs go to 0; partial frame discarded. The next frame begins with CLEAR.

## Timing
- Reset values: every output is 0; state = IDLE; counters = 0.
- Outputs are registered, except o_px_ready and o_busy, which decode the state directly.
- Start sequence:
  - Cycle of i_start in IDLE = t.
  - o_lb_clear is high in cycle t+1 (CLEAR).
  - o_px_ready is first high in t+2.
- Write latency: an accept in cycle n gives o_lb_wr_valid, o_lb_wr_data, o_win_valid, o_win_col and o_win_row in cycle n+1, all aligned.
- End of frame:
  - The last accept in cycle n moves the FSM to DONE in n+1.
  - The last write strobe and o_frame_done are both high in n+1.
  - IDLE is reached in n+2, and i_start is honoured there.
- Throughput: one pixel per cycle, with no stall at row wrap.

## Structure
- Package conv_pkg:
  - ctrl_state_t enum for IDLE/CLEAR/STREAM/DONE.
  - Localparam helper function cntw(n) = max(1, $clog2(n)), shared with line buffer and window modules.
- Sub-module raster_counter #(IMG_W, IMG_H):
  - Inputs: clear and advance.
  - Outputs: col, row, last (row = H-1 & col = W-1).
- The top module holds the FSM and output registers.

## Test plan
1. Reset, no start -> all outputs 0 for 10 cycles; i_px_valid = 1 is never accepted.
2. W=H=8, start, continuous valid with data = 0..63:
   - o_lb_clear is one cycle.
   - 64 write strobes carry data 0..63 in order.
   - The first o_win_valid is on data 18 (row 2, col 2).
   - 36 window strobes in total.
   - o_frame_done coincides with the write of data 63.
3. Bubbles: valid toggles 1,0 for the whole frame -> still exactly 64 writes and 36 windows in order; o_win_col wraps 7 -> 0 with o_win_row incrementing.
4. i_start pulsed during STREAM and DONE -> ignored; no second o_lb_clear until the FSM is back in IDLE.
5. i_reset asserted after 20 accepts -> next cycle all outputs are 0 and state is IDLE; a new start gives a full 64-pixel frame with the first window at the 19th pixel.
6. W=3, H=3 -> 9 writes, exactly one window strobe on the 9th pixel (row 2, col 2), in the same cycle as o_frame_done.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution front end.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ctrl_state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cntw(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_ctrl_raster_counter.sv
// Column/row position tracker for a raster-ordered frame.
module raster_counter
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int CW = cntw(IMG_W),
  localparam int RW = cntw(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_end;
  logic row_end;

  always_comb begin
    col_end = (col == CW'(IMG_W - 1));
    row_end = (row == RW'(IMG_H - 1));
    last    = col_end && row_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-scan sequencer feeding the line-buffer chain and 3x3 window flags.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WIDTH = 8,
  localparam int CW = cntw(IMG_W),
  localparam int RW = cntw(IMG_H)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_px_valid,
  input  logic [WIDTH-1:0] i_px_data,
  output logic             o_px_ready,
  output logic             o_lb_clear,
  output logic             o_lb_wr_valid,
  output logic [WIDTH-1:0] o_lb_wr_data,
  output logic             o_win_valid,
  output logic [CW-1:0]    o_win_col,
  output logic [RW-1:0]    o_win_row,
  output logic             o_busy,
  output logic             o_frame_done
);

  ctrl_state_t   state;
  ctrl_state_t   state_nxt;
  logic          accept;
  logic [CW-1:0] cnt_col;
  logic [RW-1:0] cnt_row;
  logic          cnt_last;

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .clk    (i_clk),
    .rst    (i_reset),
    .clear  (state == CLEAR),
    .advance(accept),
    .col    (cnt_col),
    .row    (cnt_row),
    .last   (cnt_last)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_px_ready = 1'b0;
    o_busy     = 1'b1;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = STREAM;
      STREAM: begin
        o_px_ready = 1'b1;
        accept     = i_px_valid;
        if (i_px_valid && cnt_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write-side outputs carry the accepted pixel's own position, one cycle later.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_lb_clear    <= 1'b0;
      o_lb_wr_valid <= 1'b0;
      o_lb_wr_data  <= '0;
      o_win_valid   <= 1'b0;
      o_win_col     <= '0;
      o_win_row     <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      o_lb_clear    <= (state == IDLE) && i_start;
      o_lb_wr_valid <= accept;
      o_lb_wr_data  <= accept ? i_px_data : '0;
      o_win_col     <= accept ? cnt_col : '0;
      o_win_row     <= accept ? cnt_row : '0;
      o_win_valid   <= accept && (cnt_row >= RW'(2)) && (cnt_col >= CW'(2));
      o_frame_done  <= accept && cnt_last;
    end
  end

endmodule
